// File: rtl/rca_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : rca_serial_seq
// Description : Sequential wide adder that reuses one 4-bit ripple-carry slice,
//               one slice per clock, LSB first, with a start/busy/done handshake.
// Revision    : 1.0  initial release
// ============================================================================
module rca_serial_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_as;
  logic [3:0]       w_bs;
  logic [3:0]       w_s;
  logic [4:0]       w_cy;

  // Start is honoured in IDLE and DONE alike, so DONE can chain straight into RUN.
  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_idx == C_LAST_IDX);
  assign w_as     = r_a[{r_idx, 2'b00} +: 4];
  assign w_bs     = r_b[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_s     = '0;
    w_cy    = '0;
    w_cy[0] = r_carry;
    for (int i = 0; i < 4; i++) begin
      w_s[i]    = w_as[i] ^ w_bs[i] ^ w_cy[i];
      w_cy[i+1] = (w_as[i] & w_bs[i]) | (w_cy[i] & (w_as[i] ^ w_bs[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[{r_idx, 2'b00} +: 4] <= w_s;
      r_carry <= w_cy[4];
      if (w_last) begin
        // Signed overflow: carry into the MSB differs from carry out of it.
        r_cout <= w_cy[4];
        r_ovf  <= w_cy[3] ^ w_cy[4];
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rca_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_serial_seq
// Description : Directed self-checking bench for rca_serial_seq (WIDTH=16).
// Revision    : 1.0  initial release
// ============================================================================
module tb_rca_serial_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_chk = 0;
  int n_err = 0;

  rca_serial_seq #(.WIDTH(16)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns just after the accepting edge, with operands scrambled.
  task automatic launch(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    start = 1'b1;
    a     = va;
    b     = vb;
    cin   = vc;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 16'hDEAD;
    b     = 16'hBEEF;
    cin   = ~vc;
  endtask

  // Follows one operation to its done cycle; ends at the negedge of that cycle.
  task automatic collect(input string tag, input int poke_at, input logic [15:0] es,
                         input logic ec, input logic eo);
    int lat;
    int bc;
    int ovl;
    bit got;
    lat = 1;
    bc  = 0;
    ovl = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      if (busy && done) ovl++;
      if (lat == 1) chk({tag, ".clr"}, {16'h0, sum}, 32'h0);
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) bc++;
        if (lat == poke_at) begin
          start = 1'b1;
          a     = 16'h1111;
          b     = 16'h1111;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        lat++;
      end
    end
    chk({tag, ".lat"},  lat, 5);
    chk({tag, ".busy"}, bc, 4);
    chk({tag, ".ovl"},  ovl, 0);
    chk({tag, ".sum"},  {16'h0, sum}, {16'h0, es});
    chk({tag, ".cout"}, {31'h0, cout}, {31'h0, ec});
    chk({tag, ".ovf"},  {31'h0, ovf}, {31'h0, eo});
  endtask

  task automatic op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                    input logic vc, input logic [15:0] es, input logic ec, input logic eo);
    launch(va, vb, vc);
    collect(tag, 0, es, ec, eo);
    @(negedge clk);
    chk({tag, ".dn0"},  {31'h0, done}, 32'h0);
    chk({tag, ".hold"}, {16'h0, sum}, {16'h0, es});
  endtask

  initial begin
    int dcnt;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst.busy", {31'h0, busy}, 32'h0);
    chk("rst.done", {31'h0, done}, 32'h0);
    chk("rst.sum",  {16'h0, sum}, 32'h0);
    chk("rst.cout", {31'h0, cout}, 32'h0);
    chk("rst.ovf",  {31'h0, ovf}, 32'h0);

    op("basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    op("wrap1",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op("wrapc",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    op("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    op("mixc",   16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);

    // A second start two cycles into RUN must be dropped, not queued.
    launch(16'h00FF, 16'h0101, 1'b0);
    collect("ignore", 2, 16'h0200, 1'b0, 1'b0);
    @(negedge clk);
    chk("ignore.dn0", {31'h0, done}, 32'h0);
    chk("ignore.idle", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("ignore.idle2", {31'h0, busy}, 32'h0);

    // Reset on the third RUN cycle discards the operation.
    launch(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst.busy", {31'h0, busy}, 32'h0);
    chk("mrst.done", {31'h0, done}, 32'h0);
    chk("mrst.sum",  {16'h0, sum}, 32'h0);
    chk("mrst.cout", {31'h0, cout}, 32'h0);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("mrst.nodone", dcnt, 0);
    op("after_rst", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Start held on the done cycle chains straight into the next op.
    launch(16'h7FFF, 16'h0001, 1'b0);
    collect("b2b_a", 0, 16'h8000, 1'b0, 1'b1);
    launch(16'h0F0F, 16'h00F1, 1'b1);
    collect("b2b_b", 0, 16'h1001, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b.dn0", {31'h0, done}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
